// File: rtl/reg_pkg.sv
// Shared constants and FSM state type for the multi-register store sequencer.
package reg_pkg;
  localparam int NUM_REGS  = 16;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int ADDR_STEP = 4;
  localparam int IDX_W     = $clog2(NUM_REGS);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
endpackage

// File: rtl/reg_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest request bit plus an any flag.
module reg_prio_enc #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  // Scan high-to-low so the lowest set bit wins the last assignment.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

  assign any_o = |req_i;
endmodule

// File: rtl/reg_store_seq.sv
// STM-style store sequencer: snapshots the bank on accept and streams one {addr,data} beat per listed register.
// Optional base-register writeback outputs (wb_valid, wb_addr) when STM_WRITEBACK_EN is defined.
module reg_store_seq
  import reg_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_REGS-1:0]        reg_list,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       str_valid,
  input  logic                       str_ready,
  output logic [ADDR_W-1:0]          str_addr,
  output logic [DATA_W-1:0]          str_data,
  output logic                       busy,
  output logic                       done
`ifdef STM_WRITEBACK_EN
  ,
  output logic                       wb_valid,
  output logic [ADDR_W-1:0]          wb_addr
`endif
);
  state_e                           state_q, state_d;
  logic [NUM_REGS-1:0]              mask_q, mask_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic                             busy_q, busy_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  snap_q;
  logic                             accept;
  logic [IDX_W-1:0]                 pend_idx;
  logic                             pend_any;

  reg_prio_enc #(.N(NUM_REGS), .IW(IDX_W)) u_enc (
    .req_i (mask_q),
    .idx_o (pend_idx),
    .any_o (pend_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      if (accept) snap_q <= regs_flat;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          mask_d  = reg_list;
          addr_d  = base_addr;
          // An empty list goes straight to DONE without ever raising busy.
          busy_d  = |reg_list;
          state_d = (|reg_list) ? SEND : DONE;
        end
      end
      SEND: begin
        if (str_ready) begin
          mask_d[pend_idx] = 1'b0;
          // addr_q ends at base + popcount*step, which doubles as the writeback address.
          addr_d = addr_q + ADDR_W'(ADDR_STEP);
          if (mask_d == '0) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign str_valid = (state_q == SEND) && pend_any;
  assign str_addr  = str_valid ? addr_q : '0;
  assign str_data  = str_valid ? snap_q[pend_idx] : '0;
  assign busy      = busy_q;
  assign done      = (state_q == DONE);

`ifdef STM_WRITEBACK_EN
  assign wb_valid = done;
  assign wb_addr  = addr_q;
`endif
endmodule

// File: tb/tb_reg_store_seq.sv
// Bench for reg_store_seq: queue-based reference model checked every cycle plus directed literal checks.
module tb_reg_store_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [15:0]  reg_list;
  logic [31:0]  base_addr;
  logic [511:0] regs_flat;
  logic         str_valid;
  logic         str_ready;
  logic [31:0]  str_addr;
  logic [31:0]  str_data;
  logic         busy;
  logic         done;
`ifdef STM_WRITEBACK_EN
  logic         wb_valid;
  logic [31:0]  wb_addr;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  reg_store_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .regs_flat (regs_flat),
    .str_valid (str_valid),
    .str_ready (str_ready),
    .str_addr  (str_addr),
    .str_data  (str_data),
    .busy      (busy),
    .done      (done)
`ifdef STM_WRITEBACK_EN
    ,
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a queue of pending beats built from the list at accept time.
  typedef struct { logic [31:0] a; logic [31:0] d; } beat_t;
  beat_t       q[$];
  int          m_mode;   // 0 waiting for start, 1 streaming, 2 finishing
  bit          m_busy, m_done;
  logic [31:0] m_wb;

  task automatic model_step();
    int k;
    beat_t b;
    if (rst) begin
      q.delete(); m_mode = 0; m_busy = 0; m_done = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
          k = 0;
          for (int i = 0; i < 16; i++) begin
            if (reg_list[i]) begin
              b.a = base_addr + 32'(k * 4);
              b.d = regs_flat[i*32 +: 32];
              q.push_back(b);
              k++;
            end
          end
          m_wb = base_addr + 32'(k * 4);
          if (k == 0) begin m_mode = 2; m_done = 1; end
          else begin m_mode = 1; m_busy = 1; end
        end
        1: if (str_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) begin m_mode = 2; m_done = 1; end
        end
        default: begin m_mode = 0; m_done = 0; m_busy = 0; end
      endcase
    end
  endtask

  initial begin
    m_mode = 0; m_busy = 0; m_done = 0; m_wb = '0;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (mon_en) begin
        chk("mon_valid", {31'd0, str_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0 && str_valid) begin
          chk("mon_addr", str_addr, q[0].a);
          chk("mon_data", str_data, q[0].d);
        end
        chk("mon_busy", {31'd0, busy}, {31'd0, m_busy});
        chk("mon_done", {31'd0, done}, {31'd0, m_done});
`ifdef STM_WRITEBACK_EN
        chk("mon_wbv", {31'd0, wb_valid}, {31'd0, m_done});
        if (m_done) chk("mon_wba", wb_addr, m_wb);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank(input logic [31:0] hi);
    for (int i = 0; i < 16; i++) regs_flat[i*32 +: 32] = hi + 32'(i);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0; str_ready = 1'b1;
    load_bank(32'hA000_0000);
    mon_en = 1'b1;
    step(); step();
    chk("rst_valid", {31'd0, str_valid}, 32'd0);
    chk("rst_addr", str_addr, 32'd0);
    chk("rst_data", str_data, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    rst = 1'b0;
    step();

    // 1: two beats, ready held high
    start = 1'b1; reg_list = 16'h0005; base_addr = 32'h100;
    step(); start = 1'b0;
    chk("t1_b0_addr", str_addr, 32'h100);
    chk("t1_b0_data", str_data, 32'hA000_0000);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t1_b1_addr", str_addr, 32'h104);
    chk("t1_b1_data", str_data, 32'hA000_0002);
    step();
    chk("t1_done", {30'd0, str_valid, done}, 32'd1);
    step();
    chk("t1_idle", {30'd0, busy, done}, 32'd0);

    // 2: backpressure on beat 0
    start = 1'b1; reg_list = 16'h8001; base_addr = 32'h100; str_ready = 1'b0;
    step(); start = 1'b0;
    chk("t2_hold0", str_addr, 32'h100);
    step();
    chk("t2_hold1", str_data, 32'hA000_0000);
    step();
    chk("t2_hold2", {31'd0, str_valid}, 32'd1);
    str_ready = 1'b1;
    step();
    chk("t2_b1_addr", str_addr, 32'h104);
    chk("t2_b1_data", str_data, 32'hA000_000F);
    step();
    chk("t2_done", {31'd0, done}, 32'd1);
    step();

    // 3: empty list
    start = 1'b1; reg_list = 16'h0000; base_addr = 32'h500;
    step(); start = 1'b0;
    chk("t3_n1", {29'd0, str_valid, busy, done}, 32'd1);
    step();
    chk("t3_n2", {29'd0, str_valid, busy, done}, 32'd0);

    // 4: full list, address wrap, bank changes after accept
    start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'hFFFF_FFF8;
    step(); start = 1'b0;
    load_bank(32'h5500_0000);
    chk("t4_b0_addr", str_addr, 32'hFFFF_FFF8);
    chk("t4_b0_data", str_data, 32'hA000_0000);
    step();
    chk("t4_b1_addr", str_addr, 32'hFFFF_FFFC);
    step();
    chk("t4_b2_addr", str_addr, 32'h0000_0000);
    chk("t4_b2_data", str_data, 32'hA000_0002);
    for (int i = 0; i < 13; i++) step();
    chk("t4_b15_addr", str_addr, 32'h0000_0034);
    chk("t4_b15_data", str_data, 32'hA000_000F);
    step();
    chk("t4_done", {31'd0, done}, 32'd1);
    step();
    load_bank(32'hA000_0000);

    // 5: reset mid-sequence, then immediate restart
    start = 1'b1; reg_list = 16'h00FF; base_addr = 32'h300;
    step(); start = 1'b0;
    step();
    step();
    chk("t5_b2_addr", str_addr, 32'h308);
    rst = 1'b1;
    step();
    chk("t5_abort", {29'd0, str_valid, busy, done}, 32'd0);
    rst = 1'b0; start = 1'b1; reg_list = 16'h0003; base_addr = 32'h400;
    step(); start = 1'b0;
    chk("t5_restart", str_addr, 32'h400);
    step();
    chk("t5_r_b1", str_data, 32'hA000_0001);
    step();
    chk("t5_r_done", {31'd0, done}, 32'd1);
    step();

    // 6: start during busy and in DONE is ignored; writeback address
    start = 1'b1; reg_list = 16'h00F0; base_addr = 32'h200;
    step();
    reg_list = 16'h0001; base_addr = 32'h900;
    chk("t6_b0", str_data, 32'hA000_0004);
    step(); start = 1'b0;
    chk("t6_b1", str_addr, 32'h204);
    step(); step();
    chk("t6_b3", str_data, 32'hA000_0007);
    start = 1'b1;
    step();
    chk("t6_done", {31'd0, done}, 32'd1);
`ifdef STM_WRITEBACK_EN
    chk("t6_wbv", {31'd0, wb_valid}, 32'd1);
    chk("t6_wba", wb_addr, 32'h210);
`endif
    step(); start = 1'b0;
    chk("t6_idle", {29'd0, str_valid, busy, done}, 32'd0);
    step();
    chk("t6_ignored", {31'd0, str_valid}, 32'd0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
